bridge_buffer_ctrl: RTL and testbench

Sequencing controller for one bridge-buffer bank (west or north) in the Multi-Head Attention datapath.
- Write side: accepts a full tile of words from the linear-projection stage through a valid/ready handshake and generates the port-A write controls.
- Read side: replays the stored tile to the systolic array through port B, stepping `slicing_idx` across every module slice of each word, and streams it `NUM_PASSES` times.
- Instantiated once per buffer (west and north); its outputs connect directly to the bank-0 control inputs of the buffer wrapper.

---
 rtl/bridge_buffer_ctrl.sv | 156 +++++++++++++++
 tb/tb_bridge_buffer_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_buffer_ctrl.sv
// bridge_buffer_ctrl: sequencing controller for one bridge-buffer bank.
// The write side captures one tile of TOTAL_DEPTH words through port A. The read
// side replays the tile through port B, one slice per handshake, NUM_PASSES times.
// Optional build macro: BRIDGE_BUF_CTRL_PREFETCH_EN. When it is defined, the
// fetch of the next word overlaps the last-slice handshake of the current word.
module bridge_buffer_ctrl #(
  parameter int TOTAL_MODULES = 4,
  parameter int TOTAL_DEPTH   = 12,
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_PASSES    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             bank0_ena,
  output logic                             bank0_wea,
  output logic [ADDR_WIDTH-1:0]            bank0_addra,
  output logic                             bank0_enb,
  output logic [ADDR_WIDTH-1:0]            bank0_addrb,
  output logic [$clog2(TOTAL_MODULES)-1:0] slicing_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             tile_done
);

  localparam int SW = $clog2(TOTAL_MODULES);
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [SW-1:0]         LAST_SLICE = SW'(TOTAL_MODULES - 1);
  localparam logic [PW-1:0]         LAST_PASS  = PW'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FETCH,
    S_READ
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [SW-1:0]         slice, slice_nxt;
  logic [PW-1:0]         pass, pass_nxt;
  logic                  tile_done_nxt;

  // State, pointers and the registered tile_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slice     <= '0;
      pass      <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      slice     <= slice_nxt;
      pass      <= pass_nxt;
      tile_done <= tile_done_nxt;
    end
  end

  // Next-state, counter updates and the combinational bank controls.
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    slice_nxt     = slice;
    pass_nxt      = pass;
    tile_done_nxt = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    bank0_enb     = 1'b0;
    bank0_addra   = wr_ptr;
    bank0_addrb   = rd_ptr;
    slicing_idx   = '0;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_WRITE;
      end

      S_WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr_nxt = '0;
            state_nxt  = S_FETCH;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end

      S_FETCH: begin
        bank0_enb = 1'b1;
        state_nxt = S_READ;
      end

      S_READ: begin
        out_valid   = 1'b1;
        slicing_idx = slice;
        if (out_ready) begin
          if (slice != LAST_SLICE) begin
            slice_nxt = slice + 1'b1;
          end else begin
            slice_nxt = '0;
            if (rd_ptr != LAST_ADDR) begin
              rd_ptr_nxt = rd_ptr + 1'b1;
`ifdef BRIDGE_BUF_CTRL_PREFETCH_EN
              // Issue the next word's read now so its data lands exactly when
              // slice 0 is presented; the FSM stays in S_READ.
              bank0_enb   = 1'b1;
              bank0_addrb = rd_ptr + 1'b1;
`else
              state_nxt  = S_FETCH;
`endif
            end else if (pass != LAST_PASS) begin
              pass_nxt   = pass + 1'b1;
              rd_ptr_nxt = '0;
              state_nxt  = S_FETCH;
            end else begin
              rd_ptr_nxt    = '0;
              pass_nxt      = '0;
              tile_done_nxt = 1'b1;
              state_nxt     = S_WRITE;
            end
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything. A write presented in the same cycle still
    // reaches the bank, but the pointer restarts at 0.
    if (abort) begin
      state_nxt     = S_WRITE;
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      slice_nxt     = '0;
      pass_nxt      = '0;
      tile_done_nxt = 1'b0;
    end

    bank0_ena = in_ready & in_valid;
    bank0_wea = in_ready & in_valid;
  end

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Scoreboard bench for bridge_buffer_ctrl. It models the BRAM read latency and
// the expected tile order: TOTAL_DEPTH writes, then NUM_PASSES x words x slices.
module tb_bridge_buffer_ctrl;
  localparam int TM = 2;
  localparam int TD = 4;
  localparam int AW = 8;
  localparam int NP = 3;
  localparam int SW = $clog2(TM);
`ifdef BRIDGE_BUF_CTRL_PREFETCH_EN
  localparam int READ_CYCLES = NP * (TD * TM + 1);
`else
  localparam int READ_CYCLES = NP * TD * (TM + 1);
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, bank0_ena, bank0_wea, bank0_enb, out_valid, tile_done;
  logic [AW-1:0] bank0_addra, bank0_addrb;
  logic [SW-1:0] slicing_idx;

  int checks = 0;
  int passed = 0;
  int wq[$];
  int rq_addr[$];
  int rq_slice[$];
  bit done_expected = 1'b0;
  int dout_addr = -1;
  bit ab;

  always #5 clk = ~clk;

  bridge_buffer_ctrl #(
    .TOTAL_MODULES(TM),
    .TOTAL_DEPTH  (TD),
    .ADDR_WIDTH   (AW),
    .NUM_PASSES   (NP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bank0_ena  (bank0_ena),
    .bank0_wea  (bank0_wea),
    .bank0_addra(bank0_addra),
    .bank0_enb  (bank0_enb),
    .bank0_addrb(bank0_addrb),
    .slicing_idx(slicing_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tile_done  (tile_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // BRAM model with 1-cycle read latency: records which word the dout holds.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_addr <= -1;
    else if (bank0_enb) dout_addr <= int'(bank0_addrb);
  end

  // Monitor: compares observed transfers against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      check("port_exclusive", bank0_ena & bank0_enb, 0);
      check("ready_during_read", in_ready & (out_valid | bank0_enb), 0);
      if (in_valid && in_ready) begin
        if (wq.size() == 0) check("unexpected_write", bank0_addra, -1);
        else begin
          check("wr_addr", bank0_addra, wq.pop_front());
          check("wr_enables", {bank0_ena, bank0_wea}, 3);
        end
      end else begin
        check("wr_idle", {bank0_ena, bank0_wea}, 0);
      end
      if (bank0_enb && !out_valid) check("fetch_slice0", slicing_idx, 0);
      if (out_valid) begin
        if (rq_addr.size() == 0) check("unexpected_read", slicing_idx, -1);
        else begin
          check("rd_word", dout_addr, rq_addr[0]);
          check("rd_slice", slicing_idx, rq_slice[0]);
`ifdef BRIDGE_BUF_CTRL_PREFETCH_EN
          if (bank0_enb) begin
            check("pf_slot", {out_ready, slicing_idx == SW'(TM - 1), rq_addr[0] != TD - 1}, 7);
            check("pf_addr", bank0_addrb, rq_addr[0] + 1);
          end
`else
          check("read_enb_low", bank0_enb, 0);
`endif
          if (out_ready) begin
            void'(rq_addr.pop_front());
            void'(rq_slice.pop_front());
          end else begin
            check("stall_enb", bank0_enb, 0);
          end
        end
      end
      if (tile_done) begin
        check("done_expected", done_expected, 1);
        check("done_drained", rq_addr.size() + wq.size(), 0);
        done_expected = 1'b0;
      end
    end
  end

  task automatic push_tile();
    wq.delete();
    rq_addr.delete();
    rq_slice.delete();
    for (int a = 0; a < TD; a++) wq.push_back(a);
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < TD; a++)
        for (int s = 0; s < TM; s++) begin
          rq_addr.push_back(a);
          rq_slice.push_back(s);
        end
    done_expected = 1'b1;
  endtask

  task automatic run_tile(input bit directed, input int abort_wr, input int abort_rd_word,
                          output bit aborted);
    int nwr;
    int cyc;
    int n;
    aborted = 1'b0;
    nwr = 0;
    cyc = 0;
    push_tile();
    while (nwr < TD) begin
      @(posedge clk); #1;
      in_valid  = directed ? 1'b1 : ($urandom_range(0, 9) < 7);
      out_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      abort     = 1'b0;
      #1;
      if (abort_wr == nwr && in_ready) begin
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_wr_ready", in_ready, 1);
        aborted = 1'b1;
        return;
      end
      if (in_valid && in_ready) nwr++;
      cyc++;
      if (cyc > 200) begin
        check("write_timeout", nwr, TD);
        return;
      end
    end
    @(posedge clk); #1;
    n = 0;
    forever begin
      in_valid  = 1'b0;
      abort     = 1'b0;
      out_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (tile_done) break;
      if (abort_rd_word >= 0 && out_valid && rq_addr.size() > 0 &&
          rq_addr[0] == abort_rd_word && rq_slice[0] == 0) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        check("abort_rd_ready", in_ready, 1);
        check("abort_rd_no_done", tile_done, 0);
        check("abort_rd_no_valid", out_valid, 0);
        done_expected = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (n > 600) begin
        check("read_timeout", n, READ_CYCLES);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    if (directed) check("fetch_to_done_cycles", n, READ_CYCLES);
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {in_ready, bank0_ena, bank0_wea, bank0_enb, out_valid, tile_done,
                bank0_addra, bank0_addrb, slicing_idx}, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("write_in_ready", in_ready, 1);
    check("write_addra", bank0_addra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    release_reset();

    run_tile(1'b1, -1, -1, ab);
    run_tile(1'b0, -1, 1, ab);
    check("abort_rd_taken", ab, 1);
    run_tile(1'b0, 2, -1, ab);
    check("abort_wr_taken", ab, 1);
    for (int t = 0; t < 10; t++) run_tile(1'b0, -1, -1, ab);
    run_tile(1'b1, -1, -1, ab);

    // Asynchronous reset in the middle of a read.
    push_tile();
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (TD + 4) @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("async_reset_outputs");
    wq.delete();
    rq_addr.delete();
    rq_slice.delete();
    done_expected = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    run_tile(1'b0, -1, -1, ab);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
